elastic_pipeline: RTL and testbench

Parametrised N-stage elastic pipeline register chain with per-item valid/ready flow control, per-stage selective flush and an optional registered-ready output buffer. It replaces the global stall/flush-per-stage pipeline registers between core pipeline stages with a single generic block, adding bubble collapsing and downstream backpressure. Stage 0 is the youngest stage and stage STAGES-1 the oldest.

---
 rtl/elastic_pipeline_if.sv | 33 +++
 rtl/elastic_pipeline.sv | 131 +++++++++++++
 tb/tb_elastic_pipeline.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/elastic_pipeline_if.sv
// elastic_pipeline_if: handshake and control bundle between an elastic_pipeline and its neighbours.
// Latency: none, wires only.
// Backpressure: carries i_ready (downstream) and o_ready (upstream); no behaviour of its own.
// Signals: upstream i_valid/o_ready/i_data, downstream o_valid/i_ready/o_data,
// flush controls i_flush/i_flush_all, status o_stage_valid/o_occupancy.
// master = the side that drives stimulus and consumes output; slave = the pipeline itself.
interface elastic_pipeline_if #(
    parameter int DATA_WIDTH = 64,
    parameter int STAGES     = 5
);
    localparam int OCC_W = $clog2(STAGES + 3);

    logic                  i_valid;
    logic                  o_ready;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  o_valid;
    logic                  i_ready;
    logic [DATA_WIDTH-1:0] o_data;
    logic [STAGES-1:0]     i_flush;
    logic                  i_flush_all;
    logic [STAGES-1:0]     o_stage_valid;
    logic [OCC_W-1:0]      o_occupancy;

    modport master (
        output i_valid, i_data, i_ready, i_flush, i_flush_all,
        input  o_ready, o_valid, o_data, o_stage_valid, o_occupancy
    );

    modport slave (
        input  i_valid, i_data, i_ready, i_flush, i_flush_all,
        output o_ready, o_valid, o_data, o_stage_valid, o_occupancy
    );
endinterface

// File: rtl/elastic_pipeline.sv
// elastic_pipeline: N-stage valid/ready register chain with bubble collapse, per-stage flush and flush-all.
// Latency: STAGES cycles from accept to o_valid (STAGES+1 when ELASTIC_PIPELINE_SKID_EN is defined).
// Backpressure: i_ready ripples combinationally to o_ready; ELASTIC_PIPELINE_SKID_EN adds a 2-entry output buffer that cuts that path.
// Ports: i_clk, i_arst_n (synchronous, active-low) and bus (elastic_pipeline_if.slave) holding
// the upstream/downstream handshakes, i_flush/i_flush_all, o_stage_valid and o_occupancy.
// Stage 0 is the youngest stage, stage STAGES-1 the oldest.
module elastic_pipeline #(
    parameter int DATA_WIDTH = 64,
    parameter int STAGES     = 5
) (
    input  logic              i_clk,
    input  logic              i_arst_n,
    elastic_pipeline_if.slave bus
);
    localparam int OCC_W = $clog2(STAGES + 3);

    logic [STAGES-1:0]     valid_q;
    logic [DATA_WIDTH-1:0] data_q  [STAGES];
    logic [STAGES-1:0]     ev;
    logic [STAGES-1:0]     move;
    logic [STAGES:0]       take;
    logic [STAGES-1:0]     src_vld;
    logic [DATA_WIDTH-1:0] src_dat [STAGES];
    logic                  take_out;
    logic [1:0]            buf_occ;
    logic [OCC_W-1:0]      occ;

    // Flushed stages look empty, so they accept regardless of downstream.
    // take/move resolve from the oldest stage backwards in one pass.
    always_comb begin
        ev           = valid_q & ~bus.i_flush;
        move         = '0;
        take         = '0;
        take[STAGES] = take_out;
        for (int k = STAGES - 1; k >= 0; k--) begin
            move[k] = ev[k] & take[k+1];
            take[k] = ~ev[k] | move[k];
        end
    end

    // Source of each stage: the upstream port for stage 0, the younger neighbour otherwise.
    always_comb begin
        src_vld    = '0;
        src_vld[0] = bus.i_valid;
        src_dat[0] = bus.i_data;
        for (int k = 1; k < STAGES; k++) begin
            src_vld[k] = ev[k-1];
            src_dat[k] = data_q[k-1];
        end
    end

    // A stage that cannot take is necessarily holding a live item, so valid simply holds.
    always_ff @(posedge i_clk) begin
        if (!i_arst_n) begin
            valid_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (bus.i_flush_all) begin
                    valid_q[k] <= 1'b0;
                end else if (take[k]) begin
                    valid_q[k] <= src_vld[k];
                end
                if (!bus.i_flush_all && take[k] && src_vld[k]) begin
                    data_q[k] <= src_dat[k];
                end
            end
        end
    end

`ifdef ELASTIC_PIPELINE_SKID_EN
    logic [DATA_WIDTH-1:0] buf_dat [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic                  push;
    logic                  pop;
    logic [1:0]            buf_cnt;

    // Acceptance into the buffer uses only its registered count, which is
    // what removes the i_ready -> o_ready path.
    assign take_out = (buf_cnt != 2'd2);
    assign push     = move[STAGES-1];
    assign pop      = (buf_cnt != 2'd0) & bus.i_ready;

    always_ff @(posedge i_clk) begin
        if (!i_arst_n) begin
            buf_dat[0] <= '0;
            buf_dat[1] <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            buf_cnt    <= 2'd0;
        end else if (bus.i_flush_all) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            buf_cnt <= 2'd0;
        end else begin
            if (push) begin
                buf_dat[wr_ptr] <= data_q[STAGES-1];
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            buf_cnt <= buf_cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    assign bus.o_valid = (buf_cnt != 2'd0);
    assign bus.o_data  = buf_dat[rd_ptr];
    assign buf_occ     = buf_cnt;
`else
    assign take_out    = bus.i_ready;
    assign bus.o_valid = ev[STAGES-1];
    assign bus.o_data  = data_q[STAGES-1];
    assign buf_occ     = 2'd0;
`endif

    // Occupancy counts registered state only; a flush shows up the following cycle.
    always_comb begin
        occ = OCC_W'(buf_occ);
        for (int k = 0; k < STAGES; k++) begin
            occ = occ + OCC_W'(valid_q[k]);
        end
    end

    assign bus.o_ready       = take[0] & ~bus.i_flush_all & i_arst_n;
    assign bus.o_stage_valid = valid_q;
    assign bus.o_occupancy   = occ;
endmodule

// File: tb/tb_elastic_pipeline.sv
// tb_elastic_pipeline: self-checking bench for elastic_pipeline (STAGES=5, DATA_WIDTH=64).
// Latency: inputs driven on the falling edge, outputs sampled 1 time unit later.
// Backpressure: i_ready driven from tables, hand sequences and $urandom against a queue model.
module tb_elastic_pipeline;
    localparam int DW = 64;
    localparam int S  = 5;
`ifdef ELASTIC_PIPELINE_SKID_EN
    localparam int          CAP    = S + 2;
    localparam int          LAT    = S + 1;
    localparam bit          SKID   = 1'b1;
    localparam logic [S-1:0] BC_SV = 5'b00000;
`else
    localparam int          CAP    = S;
    localparam int          LAT    = S;
    localparam bit          SKID   = 1'b0;
    localparam logic [S-1:0] BC_SV = 5'b11000;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    elastic_pipeline_if #(.DATA_WIDTH(DW), .STAGES(S)) bus ();

    elastic_pipeline #(.DATA_WIDTH(DW), .STAGES(S)) dut (
        .i_clk    (clk),
        .i_arst_n (rst_n),
        .bus      (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic         rst;
        logic         vld;
        logic [63:0]  dat;
        logic         rdy;
        logic [S-1:0] fl;
        logic         fa;
        logic         e_rdy;
        logic         e_vld;
        logic [2:0]   e_occ;
        logic [S-1:0] e_sv;
    } vec_t;

    vec_t tbl [11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [63:0] d, input logic rdy,
                        input logic [S-1:0] fl, input logic fa);
        @(negedge clk);
        rst_n           = r;
        bus.i_valid     = v;
        bus.i_data      = d;
        bus.i_ready     = rdy;
        bus.i_flush     = fl;
        bus.i_flush_all = fa;
        #1;
    endtask

    initial begin : main
        int first_acc, first_out, last_out, n_out, n_acc, gaps, seen;
        logic [63:0] q [$];
        logic [63:0] d;
        logic v, r, fa, exp_rdy;

        tbl[0]  = '{1'b0, 1'b1, 64'hAA, 1'b1, 5'b00000, 1'b0, 1'b0, 1'b0,  3'd0, 5'b00000};
        tbl[1]  = '{1'b0, 1'b1, 64'hAA, 1'b1, 5'b00000, 1'b0, 1'b0, 1'b0,  3'd0, 5'b00000};
        tbl[2]  = '{1'b1, 1'b1, 64'h01, 1'b1, 5'b00000, 1'b0, 1'b1, 1'b0,  3'd0, 5'b00000};
        tbl[3]  = '{1'b1, 1'b0, 64'h00, 1'b1, 5'b00000, 1'b0, 1'b1, 1'b0,  3'd1, 5'b00001};
        tbl[4]  = '{1'b1, 1'b0, 64'h00, 1'b0, 5'b00000, 1'b0, 1'b1, 1'b0,  3'd1, 5'b00010};
        tbl[5]  = '{1'b1, 1'b1, 64'h02, 1'b0, 5'b00000, 1'b0, 1'b1, 1'b0,  3'd1, 5'b00100};
        tbl[6]  = '{1'b1, 1'b0, 64'h00, 1'b0, 5'b00000, 1'b0, 1'b1, 1'b0,  3'd2, 5'b01001};
        tbl[7]  = '{1'b1, 1'b1, 64'h55, 1'b0, 5'b00000, 1'b1, 1'b0, !SKID, 3'd2, 5'b10010};
        tbl[8]  = '{1'b1, 1'b1, 64'h03, 1'b1, 5'b00000, 1'b0, 1'b1, 1'b0,  3'd0, 5'b00000};
        tbl[9]  = '{1'b1, 1'b0, 64'h00, 1'b1, 5'b00001, 1'b0, 1'b1, 1'b0,  3'd1, 5'b00001};
        tbl[10] = '{1'b1, 1'b0, 64'h00, 1'b1, 5'b00000, 1'b0, 1'b1, 1'b0,  3'd0, 5'b00000};

        rst_n           = 1'b0;
        bus.i_valid     = 1'b1;
        bus.i_data      = 64'hAA;
        bus.i_ready     = 1'b1;
        bus.i_flush     = '0;
        bus.i_flush_all = 1'b0;
        @(posedge clk);

        // Reset, first accepts, bubble spacing, flush-all and stage-0 flush.
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].rst, tbl[i].vld, tbl[i].dat, tbl[i].rdy, tbl[i].fl, tbl[i].fa);
            check($sformatf("tbl%0d_ready", i), bus.o_ready, tbl[i].e_rdy);
            check($sformatf("tbl%0d_valid", i), bus.o_valid, tbl[i].e_vld);
            check($sformatf("tbl%0d_occ", i), bus.o_occupancy, tbl[i].e_occ);
            check($sformatf("tbl%0d_stage_valid", i), bus.o_stage_valid, tbl[i].e_sv);
            if (!tbl[i].rst) check($sformatf("tbl%0d_rst_data", i), bus.o_data, 64'h0);
        end

        // Streaming 1..10 with i_ready held high.
        first_acc = -1; first_out = -1; last_out = -1; n_out = 0; n_acc = 0; gaps = 0;
        for (int t = 0; t < 40; t++) begin
            step(1'b1, t < 10, 64'(t + 1), 1'b1, '0, 1'b0);
            if (bus.i_valid && bus.o_ready) begin
                if (first_acc < 0) first_acc = t;
                n_acc++;
            end
            if (bus.o_valid && bus.i_ready) begin
                if (first_out < 0) first_out = t;
                check($sformatf("stream_dat%0d", n_out), bus.o_data, 64'(n_out + 1));
                if (last_out >= 0 && t != last_out + 1) gaps++;
                last_out = t;
                n_out++;
            end
        end
        check("stream_accepts", n_acc, 10);
        check("stream_latency", first_out - first_acc, LAT);
        check("stream_count", n_out, 10);
        check("stream_gaps", gaps, 0);

        // Backpressure fill then drain.
        n_acc = 0;
        for (int t = 0; t < 12; t++) begin
            step(1'b1, 1'b1, 64'h20 + 64'(n_acc), 1'b0, '0, 1'b0);
            if (bus.o_ready) n_acc++;
        end
        check("bp_accepts", n_acc, CAP);
        check("bp_ready_low", bus.o_ready, 1'b0);
        check("bp_occ", bus.o_occupancy, CAP);
        n_out = 0;
        for (int t = 0; t < 30; t++) begin
            step(1'b1, 1'b0, 64'h0, 1'b1, '0, 1'b0);
            if (t == 0) check("bp_ready_release", bus.o_ready, !SKID);
            if (t == 1) check("bp_ready_next", bus.o_ready, 1'b1);
            if (bus.o_valid && bus.i_ready) begin
                check($sformatf("bp_dat%0d", n_out), bus.o_data, 64'h20 + 64'(n_out));
                n_out++;
            end
        end
        check("bp_count", n_out, CAP);

        // Selective flush of stage 2 while stalled full.
        q.delete();
        for (int n = 0; n < CAP; n++) begin
            d = 64'h10 - 64'(CAP - S) + 64'(n);
            step(1'b1, 1'b1, d, 1'b0, '0, 1'b0);
            if (d != 64'h12) q.push_back(d);
        end
        for (int t = 0; t < 3; t++) step(1'b1, 1'b0, 64'h0, 1'b0, '0, 1'b0);
        check("sf_full", bus.o_stage_valid, 5'b11111);
        step(1'b1, 1'b0, 64'h0, 1'b0, 5'b00100, 1'b0);
        step(1'b1, 1'b0, 64'h0, 1'b0, '0, 1'b0);
        check("sf_occ", bus.o_occupancy, CAP - 1);
        check("sf_ready", bus.o_ready, 1'b1);
        for (int t = 0; t < 30; t++) begin
            step(1'b1, 1'b0, 64'h0, 1'b1, '0, 1'b0);
            if (bus.o_valid && bus.i_ready) begin
                if (q.size() == 0) check("sf_extra", bus.o_valid, 1'b0);
                else check("sf_dat", bus.o_data, q.pop_front());
            end
        end
        check("sf_left", q.size(), 0);

        // Flush-all with three items in flight and an incoming item.
        for (int n = 0; n < 3; n++) step(1'b1, 1'b1, 64'h31 + 64'(n), 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 64'h55, 1'b0, '0, 1'b1);
        check("fa_ready", bus.o_ready, 1'b0);
        step(1'b1, 1'b0, 64'h0, 1'b0, '0, 1'b0);
        check("fa_occ", bus.o_occupancy, 0);
        check("fa_stage_valid", bus.o_stage_valid, 5'b00000);
        seen = 0;
        for (int t = 0; t < 20; t++) begin
            step(1'b1, 1'b0, 64'h0, 1'b1, '0, 1'b0);
            if (bus.o_valid) seen++;
        end
        check("fa_emitted", seen, 0);

`ifndef ELASTIC_PIPELINE_SKID_EN
        // Flushing the oldest stage drops o_valid in the same cycle.
        step(1'b1, 1'b1, 64'h41, 1'b0, '0, 1'b0);
        for (int t = 0; t < 6; t++) step(1'b1, 1'b0, 64'h0, 1'b0, '0, 1'b0);
        check("fo_valid_before", bus.o_valid, 1'b1);
        check("fo_data_before", bus.o_data, 64'h41);
        step(1'b1, 1'b0, 64'h0, 1'b1, 5'b10000, 1'b0);
        check("fo_valid_flush", bus.o_valid, 1'b0);
        seen = 0;
        for (int t = 0; t < 10; t++) begin
            step(1'b1, 1'b0, 64'h0, 1'b1, '0, 1'b0);
            if (bus.o_valid) seen++;
        end
        check("fo_emitted", seen, 0);
`endif

        // Bubble collapse under a stalled output.
        step(1'b1, 1'b1, 64'h1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, 64'h0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, 64'h0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 64'h2, 1'b0, '0, 1'b0);
        for (int t = 0; t < 8; t++) step(1'b1, 1'b0, 64'h0, 1'b0, '0, 1'b0);
        check("bc_occ", bus.o_occupancy, 2);
        check("bc_stage_valid", bus.o_stage_valid, BC_SV);
        n_out = 0;
        for (int t = 0; t < 10; t++) begin
            step(1'b1, 1'b0, 64'h0, 1'b1, '0, 1'b0);
            if (bus.o_valid && bus.i_ready) begin
                check($sformatf("bc_dat%0d", n_out), bus.o_data, 64'(n_out + 1));
                n_out++;
            end
        end
        check("bc_count", n_out, 2);

        // Reset in the middle of operation.
        for (int n = 0; n < 3; n++) step(1'b1, 1'b1, 64'h61 + 64'(n), 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, 64'h66, 1'b1, '0, 1'b0);
        check("mr_ready_in_reset", bus.o_ready, 1'b0);
        step(1'b1, 1'b0, 64'h0, 1'b1, '0, 1'b0);
        check("mr_occ", bus.o_occupancy, 0);
        check("mr_valid", bus.o_valid, 1'b0);
        check("mr_ready", bus.o_ready, 1'b1);
        seen = 0;
        for (int t = 0; t < 15; t++) begin
            step(1'b1, 1'b0, 64'h0, 1'b1, '0, 1'b0);
            if (bus.o_valid) seen++;
        end
        check("mr_emitted", seen, 0);

        // Random traffic against an item-queue model.
        q.delete();
        for (int t = 0; t < 2000; t++) begin
            v  = ($urandom_range(0, 9) < 6);
            r  = ($urandom_range(0, 9) < 6);
            fa = ($urandom_range(0, 39) == 0);
            d  = {$urandom, $urandom};
            step(1'b1, v, d, r, '0, fa);
            exp_rdy = fa ? 1'b0 : (SKID ? (q.size() < CAP) : ((q.size() < S) || r));
            check("rnd_ready", bus.o_ready, exp_rdy);
            check("rnd_occ", bus.o_occupancy, q.size());
            if (bus.o_valid && r) begin
                if (q.size() == 0) check("rnd_spurious", bus.o_valid, 1'b0);
                else check("rnd_dat", bus.o_data, q.pop_front());
            end
            if (fa) q.delete();
            else if (v && exp_rdy) q.push_back(d);
        end
        for (int t = 0; t < 40; t++) begin
            step(1'b1, 1'b0, 64'h0, 1'b1, '0, 1'b0);
            if (bus.o_valid && bus.i_ready) begin
                if (q.size() == 0) check("drain_spurious", bus.o_valid, 1'b0);
                else check("drain_dat", bus.o_data, q.pop_front());
            end
        end
        check("drain_left", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
